// File: rtl/serdes_framed_if.sv
// Bus bundle for serdes_framed: enable, serial pins and both parallel handshakes.
// The design connects through the slave modport and its environment through master.
interface serdes_framed_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             rx_bit;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             rx_perr;
  logic             rx_overrun;
  logic             rx_frame_err;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_bit;

  modport master (
    output en, rx_bit, rx_ready, tx_data, tx_valid,
    input  rx_data, rx_valid, rx_perr, rx_overrun, rx_frame_err, tx_ready, tx_bit
  );

  modport slave (
    input  en, rx_bit, rx_ready, tx_data, tx_valid,
    output rx_data, rx_valid, rx_perr, rx_overrun, rx_frame_err, tx_ready, tx_bit
  );
endinterface

// File: rtl/serdes_framed.sv
// Framed serializer/deserializer: one bit per clock, start/stop framing,
// optional even parity, ready/valid handshake on both parallel sides.
module serdes_framed #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  serdes_framed_if.slave bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP, RX_RESYNC} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;

  rx_state_e        rx_state_q;
  logic [CW-1:0]    rx_cnt_q;
  logic [WIDTH-1:0] rx_shift_q;
  logic [WIDTH-1:0] rx_shift_d;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             rx_perr_q;
  logic             rx_par_err_q;
  logic             rx_overrun_q;
  logic             rx_frame_err_q;
  logic             rx_consume_s;

  tx_state_e        tx_state_q;
  logic [CW-1:0]    tx_cnt_q;
  logic [WIDTH-1:0] tx_shift_q;
  logic             tx_par_q;
  logic             tx_bit_q;
  logic             tx_ready_s;
  logic             tx_accept_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word, input logic b);
    return LSB_FIRST ? {b, word[WIDTH-1:1]} : {word[WIDTH-2:0], b};
  endfunction

  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    return LSB_FIRST ? word[0] : word[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] word);
    return LSB_FIRST ? {1'b0, word[WIDTH-1:1]} : {word[WIDTH-2:0], 1'b0};
  endfunction

  // The consumer handshake is independent of en; loading a new word overrides the clear.
  assign rx_consume_s = rx_valid_q & bus.rx_ready;
  assign rx_shift_d   = shift_in(rx_shift_q, bus.rx_bit);
  assign tx_ready_s   = bus.en & ((tx_state_q == TX_IDLE) | (tx_state_q == TX_STOP));
  assign tx_accept_s  = bus.tx_valid & tx_ready_s;

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_perr      = rx_perr_q;
  assign bus.rx_overrun   = rx_overrun_q;
  assign bus.rx_frame_err = rx_frame_err_q;
  assign bus.tx_ready     = tx_ready_s;
  assign bus.tx_bit       = tx_bit_q;

  // Receive FSM, deserializer and output word register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= {CW{1'b0}};
      rx_shift_q     <= {WIDTH{1'b0}};
      rx_data_q      <= {WIDTH{1'b0}};
      rx_valid_q     <= 1'b0;
      rx_perr_q      <= 1'b0;
      rx_par_err_q   <= 1'b0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
      if (rx_consume_s) begin
        rx_valid_q <= 1'b0;
      end
      if (bus.en) begin
        case (rx_state_q)
          RX_IDLE: begin
            if (!bus.rx_bit) begin
              rx_state_q   <= RX_DATA;
              rx_cnt_q     <= {CW{1'b0}};
              rx_par_err_q <= 1'b0;
            end
          end
          RX_DATA: begin
            rx_shift_q <= rx_shift_d;
            if (rx_cnt_q == LAST) begin
              rx_cnt_q   <= {CW{1'b0}};
              rx_state_q <= PARITY_EN ? RX_PAR : RX_STOP;
            end else begin
              rx_cnt_q <= rx_cnt_q + CW'(1);
            end
          end
          RX_PAR: begin
            rx_par_err_q <= even_parity(rx_shift_q) ^ bus.rx_bit;
            rx_state_q   <= RX_STOP;
          end
          RX_STOP: begin
            if (bus.rx_bit) begin
              if (!rx_valid_q || rx_consume_s) begin
                rx_data_q  <= rx_shift_q;
                rx_perr_q  <= rx_par_err_q;
                rx_valid_q <= 1'b1;
              end else begin
                rx_overrun_q <= 1'b1;
              end
              rx_state_q <= RX_IDLE;
            end else begin
              rx_frame_err_q <= 1'b1;
              rx_state_q     <= RX_RESYNC;
            end
          end
          RX_RESYNC: begin
            if (bus.rx_bit) begin
              rx_state_q <= RX_IDLE;
            end
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end
    end
  end

  // Transmit FSM; tx_bit always shows the bit belonging to the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= {CW{1'b0}};
      tx_shift_q <= {WIDTH{1'b0}};
      tx_par_q   <= 1'b0;
      tx_bit_q   <= 1'b1;
    end else if (bus.en) begin
      case (tx_state_q)
        TX_IDLE, TX_STOP: begin
          if (tx_accept_s) begin
            tx_shift_q <= bus.tx_data;
            tx_par_q   <= even_parity(bus.tx_data);
            tx_state_q <= TX_START;
            tx_bit_q   <= 1'b0;
          end else begin
            tx_state_q <= TX_IDLE;
            tx_bit_q   <= 1'b1;
          end
        end
        TX_START: begin
          tx_bit_q   <= first_bit(tx_shift_q);
          tx_shift_q <= shift_out(tx_shift_q);
          tx_cnt_q   <= {CW{1'b0}};
          tx_state_q <= TX_DATA;
        end
        TX_DATA: begin
          if (tx_cnt_q == LAST) begin
            tx_cnt_q   <= {CW{1'b0}};
            tx_state_q <= PARITY_EN ? TX_PAR : TX_STOP;
            tx_bit_q   <= PARITY_EN ? tx_par_q : 1'b1;
          end else begin
            tx_cnt_q   <= tx_cnt_q + CW'(1);
            tx_bit_q   <= first_bit(tx_shift_q);
            tx_shift_q <= shift_out(tx_shift_q);
          end
        end
        TX_PAR: begin
          tx_state_q <= TX_STOP;
          tx_bit_q   <= 1'b1;
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_bit_q   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/serdes_framed.md
# serdes_framed

Parametrised framed serializer/deserializer, the successor to the single-byte serial-in path of `tt_um_serdes`. It adds:
- configurable word width and bit order
- start/stop framing with optional even parity
- a ready/valid handshake on both parallel sides
- overrun and framing-error detection

It carries one bit per clock and sits between the chip-level pin wrapper and the parallel datapath.

## Interface
- `WIDTH`, 8: data bits per frame; legal 2..32.
- `PARITY_EN`, 1: 1 = an even-parity bit follows the data; 0 = no parity bit.
- `LSB_FIRST`, 1: 1 = data is sent and received LSB first; 0 = MSB first.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  global enable; when 0, both FSMs and the shift registers hold.
- `rx_bit`  in  1  serial input; line idles high.
- `rx_data`  out  WIDTH  received word.
- `rx_valid`  out  1  `rx_data` holds an unconsumed word.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid & rx_ready`.
- `rx_perr`  out  1  parity mismatch for the word in `rx_data`; meaningful only while `rx_valid` is high.
- `rx_overrun`  out  1  one-cycle pulse: a completed frame was dropped because `rx_valid` was still high.
- `rx_frame_err`  out  1  one-cycle pulse: the stop bit was sampled as 0.
- `tx_data`  in  WIDTH  word to send.
- `tx_valid`  in  1  `tx_data` is offered.
- `tx_ready`  out  1  combinational: `en & (tx_state==IDLE | tx_state==STOP)`.
- `tx_bit`  out  1  serial output, registered.

## Operation
Frame format, F = WIDTH + 2 + PARITY_EN bits:
- start bit 0
- WIDTH data bits
- parity bit, if PARITY_EN; equals the XOR of the data bits
- stop bit 1

RX FSM (IDLE, DATA, PAR, STOP, RESYNC); `rx_bit` is sampled on every `en` edge:
- IDLE: `rx_bit`=0 → DATA; bit counter cleared.
- DATA: shift one bit per cycle into position, following LSB_FIRST. After WIDTH bits → PAR if PARITY_EN, else STOP.
- PAR: capture the parity bit and compare it with the XOR of the data bits → STOP.
- STOP, `rx_bit`=1:
  - If `rx_valid`=0 or it is being consumed this cycle: load `rx_data` and `rx_perr`, set `rx_valid`.
  - Otherwise: drop the word, keep the old `rx_data`, pulse `rx_overrun`.
  - Next state IDLE.
- STOP, `rx_bit`=0: drop the word, pulse `rx_frame_err`, next state RESYNC.
- RESYNC: wait for `rx_bit`=1, then go to IDLE. A held-low line never retriggers a start.
- `rx_valid` clears on `rx_valid & rx_ready` unless a new word loads in the same cycle; load wins, so `rx_valid` stays 1 with new data.
- The `rx_ready` handshake works regardless of `en`.

TX FSM (IDLE, START, DATA, PAR, STOP):
- Accept on `tx_valid & tx_ready`: latch `tx_data`, compute parity, next state START.
- START drives 0; DATA drives WIDTH bits in the LSB_FIRST order; PAR drives parity; STOP drives 1.
- In STOP, an accepted word goes directly to START (gapless streaming); otherwise → IDLE.
- IDLE drives `tx_bit`=1.

Counters are `$clog2(WIDTH)` bits wide and never wrap past WIDTH-1.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_perr`=0, `rx_overrun`=0, `rx_frame_err`=0, `tx_bit`=1, both FSMs IDLE. `tx_ready`=1 once `en`=1.
- Reset asserted mid-frame aborts both frames immediately. `tx_bit` returns to 1 asynchronously and the partial RX word is discarded.
- RX latency: `rx_valid` rises on the edge that samples the stop bit, i.e. F-1 enabled edges after the edge that sampled the start bit.
- RX accepts back-to-back frames: a start bit in the cycle right after the stop bit is detected.
- TX latency: the start bit appears on `tx_bit` after the accept edge. Consecutive frames are exactly F cycles apart when `tx_valid` is held high.
- `en`=0 freezes all FSM and shift state. Pulses do not fire and `tx_ready`=0. Frames resume bit-exact when `en` returns to 1.

## Test plan
All scenarios use WIDTH=8, PARITY_EN=1, LSB_FIRST=1, so F=11.
- Reset, then `en`=1 → `tx_bit`=1, `rx_valid`=0, `tx_ready`=1, no error pulses.
- TX 0xA5 → `tx_bit` sequence 0, 1,0,1,0,0,1,0,1, 0, 1. `tx_ready` is low from the start-bit cycle until the stop-bit cycle.
- RX frame 0, eight 1s, 0, 1 → `rx_data`=0xFF, `rx_valid`=1, `rx_perr`=0. The same frame with parity bit 1 → `rx_perr`=1.
- RX frames 0x3C then 0xC3 back-to-back with `rx_ready`=0 → `rx_data` stays 0x3C and `rx_overrun` pulses once at the second stop bit.
- RX frame 0x55 with stop bit 0, line held low 5 cycles, then high 2 cycles, then frame 0x12 → one `rx_frame_err` pulse, no `rx_valid` for 0x55, then `rx_data`=0x12.
- Loopback (`tx_bit`→`rx_bit`) streaming 0x00..0x0F with `tx_valid` held and `rx_ready`=1 → 16 words in order, `rx_valid` pulses exactly 11 cycles apart. A `rst` pulse mid-frame clears everything and the next frame is received correctly.
